aes_128_decrypt_iterative: RTL



---
 rtl/aes_dec_pkg.sv | 56 +++++
 rtl/aes_inv_sbox.sv | 17 +
 rtl/sbox.sv | 17 +
 rtl/aes_128_decrypt_iterative.sv | 125 ++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared types, round constants and GF(2^8) helpers for the AES-128 inverse cipher.
package aes_dec_pkg;

  typedef enum logic [2:0] {IDLE, KEYEXP, READY, ROUND, DONE} state_t;

  // Indexed directly by the 4-bit round counter; only entries 1..10 are meaningful.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // Byte (row r, column c) lives at bits [127-8*(4c+r) -: 8].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3),
            gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3),
            gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3),
            gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
            inv_mix_column(s[63:32]), inv_mix_column(s[31:0])};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational AES inverse S-box for the InvSubBytes data path.
module aes_inv_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  localparam logic [0:255][7:0] T = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign o_out = T[i_in];
endmodule

// File: rtl/sbox.sv
// sbox: combinational AES forward S-box, used by the key schedule SubWord.
module sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  localparam logic [0:255][7:0] T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_out = T[i_in];
endmodule

// File: rtl/aes_128_decrypt_iterative.sv
// aes_128_decrypt_iterative: AES-128 inverse cipher, one round per clock, round keys regenerated backwards from K10.
// Optional AES_DEC_KEY_CHECK_EN: compare the regenerated K0 against the loaded key and raise sticky key_err.
module aes_128_decrypt_iterative #(
  parameter int NR    = 10,
  parameter int BLK_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [BLK_W-1:0] key,
  output logic             key_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] ciphertext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] plaintext,
  output logic             key_err
);
  import aes_dec_pkg::*;

  if (NR != 10 || BLK_W != 128) begin : g_param_check
    $error("aes_128_decrypt_iterative supports only NR=10 and BLK_W=128");
  end

  state_t r_state, w_next;
  logic [3:0] r_rc;
  logic [BLK_W-1:0] r_wkey, r_k10, r_data;
  logic [31:0] w_w0, w_w1, w_w2, w_w3, w_inv3, w_sw_in, w_sw_out, w_rcon, w_f0, w_f1, w_f2;
  logic [BLK_W-1:0] w_kfwd, w_kinv, w_isr, w_isb, w_ark, w_data_nxt;
  logic w_load_key, w_accept;

  assign {w_w0, w_w1, w_w2, w_w3} = r_wkey;
  assign w_inv3 = w_w3 ^ w_w2;
  // The four SubWord S-boxes are shared: forward schedule in KEYEXP, inverse schedule in ROUND.
  assign w_sw_in = (r_state == ROUND) ? {w_inv3[23:0], w_inv3[31:24]} : {w_w3[23:0], w_w3[31:24]};
  assign w_rcon = {RCON[r_rc], 24'h0};

  for (genvar i = 0; i < 4; i++) begin : g_sw
    sbox u_sbox (.i_in(w_sw_in[8*i +: 8]), .o_out(w_sw_out[8*i +: 8]));
  end

  assign w_f0 = w_w0 ^ w_sw_out ^ w_rcon;
  assign w_f1 = w_w1 ^ w_f0;
  assign w_f2 = w_w2 ^ w_f1;
  assign w_kfwd = {w_f0, w_f1, w_f2, w_w3 ^ w_f2};
  assign w_kinv = {w_w0 ^ w_sw_out ^ w_rcon, w_w1 ^ w_w0, w_w2 ^ w_w1, w_inv3};

  assign w_isr = inv_shift_rows(r_data);

  for (genvar i = 0; i < 16; i++) begin : g_isb
    aes_inv_sbox u_inv_sbox (.i_in(w_isr[8*i +: 8]), .o_out(w_isb[8*i +: 8]));
  end

  assign w_ark = w_isb ^ w_kinv;
  assign w_data_nxt = (r_rc == 4'd1) ? w_ark : inv_mix_columns(w_ark);

  assign w_load_key = key_load && (r_state == IDLE || r_state == READY);
  assign w_accept = in_valid && !key_load && r_state == READY;

  always_ff @(posedge clk)
    r_state <= !rst_n ? IDLE : w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = key_load ? KEYEXP : IDLE;
      KEYEXP:  w_next = (r_rc == 4'd10) ? READY : KEYEXP;
      READY:   w_next = key_load ? KEYEXP : (in_valid ? ROUND : READY);
      ROUND:   w_next = (r_rc == 4'd1) ? DONE : ROUND;
      DONE:    w_next = out_ready ? READY : DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rc   <= '0;
      r_wkey <= '0;
      r_k10  <= '0;
      r_data <= '0;
    end else if (w_load_key) begin
      r_wkey <= key;
      r_rc   <= 4'd1;
    end else if (r_state == KEYEXP) begin
      r_wkey <= w_kfwd;
      r_rc   <= r_rc + 4'd1;
      if (r_rc == 4'd10) r_k10 <= w_kfwd;
    end else if (w_accept) begin
      r_data <= ciphertext ^ r_k10;
      r_wkey <= r_k10;
      r_rc   <= 4'd10;
    end else if (r_state == ROUND) begin
      r_data <= w_data_nxt;
      r_wkey <= w_kinv;
      r_rc   <= r_rc - 4'd1;
    end
  end

  assign key_ready = r_state == READY || r_state == ROUND || r_state == DONE;
  assign in_ready  = r_state == READY;
  assign out_valid = r_state == DONE;
  assign plaintext = r_data;

`ifdef AES_DEC_KEY_CHECK_EN
  logic [BLK_W-1:0] r_orig;
  logic r_key_err;
  // After the last inverse step the schedule must have walked back to the loaded key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_orig    <= '0;
      r_key_err <= 1'b0;
    end else if (w_load_key) begin
      r_orig    <= key;
      r_key_err <= 1'b0;
    end else if (r_state == ROUND && r_rc == 4'd1 && w_kinv != r_orig) begin
      r_key_err <= 1'b1;
    end
  end
  assign key_err = r_key_err;
`else
  assign key_err = 1'b0;
`endif

endmodule
